// File: rtl/hdmi_sched_pkg.sv
// Shared types and constants for the HDMI period scheduler.
// Island logic is built only when HDMI_DATA_ISLAND_EN is defined.
package hdmi_sched_pkg;

  typedef enum logic [2:0] {
    CTRL   = 3'd0,
    VIDEO  = 3'd1,
    VGUARD = 3'd2,
    ISLAND = 3'd3,
    IGUARD = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    ISL_PRE,
    ISL_LGUARD,
    ISL_DATA,
    ISL_TGUARD
  } isl_state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int MIN_CTRL     = 4;

  // room to open an island / to append one more packet
  localparam int ISL_ROOM =
    PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN + MIN_CTRL;
  localparam int PKT_ROOM =
    PACKET_LEN + GUARD_LEN + MIN_CTRL;

  typedef struct packed {
    logic [1:0] c2;
    logic [1:0] c1;
  } ctl_t;

  localparam ctl_t CTL_NONE    = '{c2: 2'b00, c1: 2'b00};
  localparam ctl_t CTL_VID_PRE = '{c2: 2'b00, c1: 2'b01};
  localparam ctl_t CTL_ISL_PRE = '{c2: 2'b01, c1: 2'b01};

endpackage

// File: rtl/hdmi_island_fsm.sv
// Data-island sequencer: preamble, guards, packets and the
// packet_req/packet_ack handshake. Outputs describe the pixel now on cx.
module hdmi_island_fsm
  import hdmi_sched_pkg::*;
#(
  parameter int BIT_WIDTH    = 10,
  parameter int FRAME_WIDTH  = 800,
  parameter int SCREEN_WIDTH = 640,
  parameter int MAX_PACKETS  = 18
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic                 line_blank,
  input  logic                 next_row_active,
  input  logic                 blocked,
  input  logic                 packet_req,
  output logic                 busy,
  output mode_t                isl_mode,
  output ctl_t                 isl_ctl,
  output logic                 packet_ack,
  output logic                 island_first,
  output logic [4:0]           packet_counter
);

  typedef logic [BIT_WIDTH:0] xw_t;

  localparam xw_t LIM_VID =
    xw_t'(FRAME_WIDTH - GUARD_LEN - PREAMBLE_LEN);
  localparam xw_t LIM_BLK = xw_t'(FRAME_WIDTH);
  localparam logic [BIT_WIDTH-1:0] CTRL_VID =
    BIT_WIDTH'(SCREEN_WIDTH + MIN_CTRL);
  localparam logic [BIT_WIDTH-1:0] CTRL_BLK =
    BIT_WIDTH'(MIN_CTRL);
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] GRD_LAST = 5'(GUARD_LEN - 1);
  localparam logic [4:0] PKT_LAST = 5'(PACKET_LEN - 1);
  localparam logic [4:0] PKT_MAX  = 5'(MAX_PACKETS);

  isl_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] pkts_q, pkts_d;
  xw_t        cx_w, limit;
  logic       ctrl_ok, start, more;

  assign cx_w    = {1'b0, cx};
  assign limit   = next_row_active ? LIM_VID : LIM_BLK;
  assign ctrl_ok = cx >= (line_blank ? CTRL_BLK : CTRL_VID);
  assign start   = packet_req && !blocked && ctrl_ok &&
                   (cx_w + xw_t'(ISL_ROOM) <= limit);
  assign more    = packet_req && (pkts_q < PKT_MAX) &&
                   (cx_w + xw_t'(PKT_ROOM) <= limit);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkts_q  <= pkts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    pkts_d  = pkts_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = ISL_PRE;
      end
      ISL_PRE:
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = packet_req ? ISL_LGUARD : IDLE;
        end
      ISL_LGUARD:
        if (cnt_q == GRD_LAST) begin
          cnt_d = '0;
          if (packet_req) begin
            state_d = ISL_DATA;
            pkts_d  = 5'd1;
          end else begin
            state_d = ISL_TGUARD;
          end
        end
      ISL_DATA:
        if (cnt_q == PKT_LAST) begin
          cnt_d = '0;
          if (more) pkts_d = pkts_q + 5'd1;
          else state_d = ISL_TGUARD;
        end
      ISL_TGUARD:
        if (cnt_q == GRD_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    isl_mode = CTRL;
    isl_ctl  = CTL_NONE;
    unique case (state_d)
      ISL_PRE:                isl_ctl  = CTL_ISL_PRE;
      ISL_LGUARD, ISL_TGUARD: isl_mode = IGUARD;
      ISL_DATA:               isl_mode = ISLAND;
      default:                busy     = 1'b0;
    endcase
  end

  assign packet_ack     = (state_d == ISL_DATA) && (cnt_d == 5'd0);
  assign island_first   = packet_ack && (pkts_d == 5'd1);
  assign packet_counter = (state_d == ISL_DATA) ? cnt_d : 5'd0;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period selection, registered one cycle after cx/cy.
// Define HDMI_DATA_ISLAND_EN to include the data-island sequencer.
module hdmi_period_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  packet_req,
  output logic                  packet_ack,
  output logic [4:0]            packet_counter,
  output logic                  island_first,
  output logic [2:0]            mode,
  output logic [1:0]            ctrl0,
  output logic [1:0]            ctrl1,
  output logic [1:0]            ctrl2
);

  localparam logic [BIT_WIDTH-1:0] X_SW =
    BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0] X_VGUARD =
    BIT_WIDTH'(FRAME_WIDTH - GUARD_LEN);
  localparam logic [BIT_WIDTH-1:0] X_VPRE =
    BIT_WIDTH'(FRAME_WIDTH - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [BIT_HEIGHT-1:0] Y_SH =
    BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] Y_SH_M1 =
    BIT_HEIGHT'(SCREEN_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST =
    BIT_HEIGHT'(FRAME_HEIGHT - 1);

  logic  line_blank, next_row_active;
  logic  video, vguard, vpre;
  logic  isl_busy, isl_ack, isl_first;
  logic  [4:0] isl_cnt;
  mode_t isl_mode, mode_d;
  ctl_t  isl_ctl, ctl_d;

  // the last frame line is followed by active line 0
  assign line_blank      = cy >= Y_SH;
  assign next_row_active = (cy == Y_LAST) || (cy < Y_SH_M1);
  assign video  = !line_blank && (cx < X_SW);
  assign vguard = next_row_active && (cx >= X_VGUARD);
  assign vpre   = next_row_active && (cx >= X_VPRE) &&
                  (cx < X_VGUARD);

`ifdef HDMI_DATA_ISLAND_EN
  hdmi_island_fsm #(
    .BIT_WIDTH   (BIT_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH),
    .SCREEN_WIDTH(SCREEN_WIDTH),
    .MAX_PACKETS (MAX_PACKETS)
  ) u_island (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .cx             (cx),
    .line_blank     (line_blank),
    .next_row_active(next_row_active),
    .blocked        (video || vguard || vpre),
    .packet_req     (packet_req),
    .busy           (isl_busy),
    .isl_mode       (isl_mode),
    .isl_ctl        (isl_ctl),
    .packet_ack     (isl_ack),
    .island_first   (isl_first),
    .packet_counter (isl_cnt)
  );
`else
  logic unused_req;
  assign unused_req = packet_req;
  assign isl_busy   = 1'b0;
  assign isl_mode   = CTRL;
  assign isl_ctl    = CTL_NONE;
  assign isl_ack    = 1'b0;
  assign isl_first  = 1'b0;
  assign isl_cnt    = 5'd0;
`endif

  always_comb begin
    mode_d = CTRL;
    ctl_d  = CTL_NONE;
    if (video) begin
      mode_d = VIDEO;
    end else if (vguard) begin
      mode_d = VGUARD;
    end else if (vpre) begin
      ctl_d = CTL_VID_PRE;
    end else if (isl_busy) begin
      mode_d = isl_mode;
      ctl_d  = isl_ctl;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mode           <= 3'd0;
      ctrl0          <= 2'b00;
      ctrl1          <= 2'b00;
      ctrl2          <= 2'b00;
      packet_ack     <= 1'b0;
      island_first   <= 1'b0;
      packet_counter <= 5'd0;
    end else begin
      mode           <= mode_d;
      ctrl0          <= {vsync, hsync};
      ctrl1          <= ctl_d.c1;
      ctrl2          <= ctl_d.c2;
      packet_ack     <= isl_ack;
      island_first   <= isl_first;
      packet_counter <= isl_cnt;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler (640x480 timing).
// Island checks compile in when HDMI_DATA_ISLAND_EN is defined.
module tb_hdmi_period_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] cx = '0;
  logic [9:0] cy = '0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       packet_req = 1'b0;
  logic       packet_ack;
  logic [4:0] packet_counter;
  logic       island_first;
  logic [2:0] mode;
  logic [1:0] ctrl0, ctrl1, ctrl2;

  int tests = 0;
  int fails = 0;

  hdmi_period_scheduler dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .cx            (cx),
    .cy            (cy),
    .hsync         (hsync),
    .vsync         (vsync),
    .packet_req    (packet_req),
    .packet_ack    (packet_ack),
    .packet_counter(packet_counter),
    .island_first  (island_first),
    .mode          (mode),
    .ctrl0         (ctrl0),
    .ctrl1         (ctrl1),
    .ctrl2         (ctrl2)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y);
    cx    = 10'(x);
    cy    = 10'(y);
    hsync = (x >= 656) && (x < 752);
    vsync = (y >= 490) && (y < 492);
  endtask

  task automatic step(input int x, input int y);
    drive(x, y);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic run_line(input int y, input int ev, input int eg,
                          input int ep);
    int nv = 0, ng = 0, np = 0, nbad = 0, nc0 = 0, nis = 0;
    for (int x = 0; x < 800; x++) begin
      step(x, y);
      if (mode == 3'd1) begin
        nv++;
        if (x >= 640) nbad++;
      end
      if (mode == 3'd2) begin
        ng++;
        if (x < 798) nbad++;
      end
      if (mode == 3'd0 && ctrl1 == 2'b01 && ctrl2 == 2'b00) begin
        np++;
        if (x < 790 || x > 797) nbad++;
      end
      if (ctrl0 !== {vsync, hsync}) nc0++;
      if (mode > 3'd2 || packet_ack || ctrl2 != 2'b00) nis++;
    end
    chk($sformatf("line%0d_video", y), nv, ev);
    chk($sformatf("line%0d_vguard", y), ng, eg);
    chk($sformatf("line%0d_vpre", y), np, ep);
    chk($sformatf("line%0d_misplaced", y), nbad, 0);
    chk($sformatf("line%0d_ctrl0", y), nc0, 0);
    chk($sformatf("line%0d_island", y), nis, 0);
  endtask

`ifdef HDMI_DATA_ISLAND_EN
  task automatic run_island(input int y, input int x0, input int n);
    int dend = 10 + 32 * n;
    int em;
    bit ind;
    packet_req = 1'b1;
    for (int k = 0; k <= dend + 2; k++) begin
      step(x0 + k, y);
      em  = k < 8 ? 0 : k < 10 ? 4 : k < dend ? 3 :
            k < dend + 2 ? 4 : 0;
      ind = (k >= 10) && (k < dend);
      chk("isl_mode", mode, em);
      chk("isl_ctrl1", ctrl1, k < 8 ? 1 : 0);
      chk("isl_ctrl2", ctrl2, k < 8 ? 1 : 0);
      chk("isl_ack", packet_ack, ind && ((k - 10) % 32 == 0));
      chk("isl_first", island_first, k == 10);
      chk("isl_cnt", packet_counter, ind ? (k - 10) % 32 : 0);
      if (n < 18 && k == dend - 32) packet_req = 1'b0;
      if (k == dend + 1) packet_req = 1'b0;
    end
  endtask
`endif

  initial begin
    drive(0, 0);
    #2 reset = 1'b1;
    @(posedge clk_pixel);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_ctrl", {ctrl0, ctrl1, ctrl2}, 0);
    chk("rst_ack", {packet_ack, island_first, packet_counter}, 0);
    reset = 1'b0;

    // test 1: active, last-active, blank and wrap lines
    run_line(478, 640, 2, 8);
    run_line(479, 640, 0, 0);
    run_line(480, 0, 0, 0);
    run_line(490, 0, 0, 0);
    run_line(524, 0, 2, 8);
    run_line(0, 640, 2, 8);

    // test 2: preamble on line 0 and one-cycle latency
    step(789, 0);
    chk("lat_789_ctrl1", ctrl1, 0);
    drive(790, 0);
    #1;
    chk("lat_hold_ctrl1", ctrl1, 0);
    @(posedge clk_pixel);
    #1;
    chk("pre790_mode", mode, 0);
    chk("pre790_ctrl1", ctrl1, 1);
    for (int x = 791; x <= 797; x++) begin
      step(x, 0);
      chk("pre_mode", mode, 0);
      chk("pre_ctrl", {ctrl2, ctrl1}, 4'b0001);
    end
    step(798, 0);
    chk("guard798_mode", mode, 2);
    chk("guard798_ctrl", {ctrl2, ctrl1}, 0);

    // test 5: too little room before the preamble
    packet_req = 1'b1;
    begin
      int np = 0, nis = 0;
      for (int x = 745; x < 800; x++) begin
        step(x, 10);
        if (mode > 3'd2 || packet_ack || ctrl2 != 2'b00) nis++;
        if (mode == 3'd0 && ctrl1 == 2'b01) np++;
      end
      chk("room45_island", nis, 0);
      chk("room45_vpre", np, 8);
    end
    packet_req = 1'b0;

`ifdef HDMI_DATA_ISLAND_EN
    // test 3: single packet island
    run_island(490, 650, 1);
    // test 4: 18 back-to-back packets
    run_island(495, 4, 18);
`else
    packet_req = 1'b1;
    begin
      int nis = 0;
      for (int x = 650; x < 700; x++) begin
        step(x, 490);
        if (mode != 3'd0 || packet_ack || island_first ||
            ctrl1 != 2'b00 || ctrl2 != 2'b00) nis++;
      end
      chk("noisl_quiet", nis, 0);
    end
    packet_req = 1'b0;
`endif

    // test 6: asynchronous reset mid-video and mid-island
    step(300, 5);
    chk("pre_rst_video", mode, 1);
    reset = 1'b1;
    #1;
    chk("arst_video_mode", mode, 0);
    reset = 1'b0;
    packet_req = 1'b1;
    for (int x = 100; x <= 120; x++) step(x, 492);
`ifdef HDMI_DATA_ISLAND_EN
    chk("pre_rst_island", mode, 3);
`endif
    reset = 1'b1;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_ctrl", {ctrl0, ctrl1, ctrl2}, 0);
    chk("arst_ack", {packet_ack, island_first, packet_counter}, 0);
    step(121, 492);
    chk("arst_hold_mode", mode, 0);
    packet_req = 1'b0;
    reset = 1'b0;
    step(122, 492);
    chk("post_rst_mode", mode, 0);
    chk("post_rst_ack", packet_ack, 0);
`ifdef HDMI_DATA_ISLAND_EN
    run_island(493, 100, 1);
`else
    run_line(5, 640, 2, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
